// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared FFT scheduling types and defaults.
package fft_sched_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic SRC_PRE  = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam int NFFT_DEF  = 256;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/frame_tag_fifo.sv
// frame_tag_fifo: 1-bit source-tag FIFO, one entry per granted frame.
module frame_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: round-robin, frame-granular sharing of the FFT input
// between two sample producers, tagging each output frame with its source.
module fft_frame_arbiter
    import fft_sched_pkg::*;
#(
    parameter int NFFT      = NFFT_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TAG_DEPTH = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] R0_DAT_I,
    input  logic        R0_CYC_I,
    input  logic        R0_STB_I,
    input  logic        R0_WE_I,
    output logic        R0_ACK_O,
    input  logic [31:0] R1_DAT_I,
    input  logic        R1_CYC_I,
    input  logic        R1_STB_I,
    input  logic        R1_WE_I,
    output logic        R1_ACK_O,
    output logic [31:0] M_DAT_O,
    output logic        M_CYC_O,
    output logic        M_STB_O,
    output logic        M_WE_O,
    input  logic        M_ACK_I,
    input  logic        FO_STB_I,
    input  logic        FO_ACK_I,
    output logic [1:0]  GNT_O,
    output logic        TAG_O,
    output logic        TAG_VAL_O,
    output logic        ERR_O
);
    state_t           state, state_nxt;
    logic             own, last, sel, grant;
    logic             req0, req1, own_req;
    logic             in_acc, out_acc, pop;
    logic             tag_full, tag_empty, err;
    logic [CNT_W-1:0] in_cnt, out_cnt;

    assign req0    = R0_CYC_I & R0_STB_I & R0_WE_I;
    assign req1    = R1_CYC_I & R1_STB_I & R1_WE_I;
    assign sel     = (req0 & req1) ? ~last : req1;
    assign own_req = own ? req1 : req0;
    assign in_acc  = (state == BUSY) & own_req & M_ACK_I;
    assign out_acc = FO_STB_I & FO_ACK_I;
    assign pop     = out_acc & (out_cnt == CNT_W'(NFFT-1));
    assign ERR_O   = err;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        M_CYC_O   = 1'b0;
        M_STB_O   = 1'b0;
        M_WE_O    = 1'b0;
        M_DAT_O   = '0;
        R0_ACK_O  = 1'b0;
        R1_ACK_O  = 1'b0;
        GNT_O     = 2'b00;
        if (state == IDLE) begin
            grant = (req0 | req1) & ~tag_full;
            if (grant)
                state_nxt = BUSY;
        end else begin
            M_CYC_O  = 1'b1;
            M_STB_O  = own_req;
            M_WE_O   = own ? R1_WE_I : R0_WE_I;
            M_DAT_O  = own ? R1_DAT_I : R0_DAT_I;
            R0_ACK_O = ~own & M_ACK_I;
            R1_ACK_O = own & M_ACK_I;
            GNT_O    = (own == SRC_DATA) ? 2'b10 : 2'b01;
            if (in_acc && in_cnt == CNT_W'(NFFT-1))
                state_nxt = IDLE;
        end
    end

    // Input counter freezes while the owner stalls, so a frame is never split.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            own     <= SRC_PRE;
            last    <= SRC_DATA;
            in_cnt  <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (grant) begin
                own    <= sel;
                last   <= sel;
                in_cnt <= '0;
            end else if (in_acc) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (out_acc)
                out_cnt <= out_cnt + CNT_W'(1);
            if (pop & tag_empty)
                err <= 1'b1;
        end
    end

    frame_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .push  (grant),
        .pop   (pop),
        .din   (sel),
        .dout  (TAG_O),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign TAG_VAL_O = ~tag_empty;

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

- Shares the single FFT wrapper between two Wishbone-style sample producers:
  - Requester 0: preamble / channel-estimation path.
  - Requester 1: data-symbol path.
- Grants ownership for exactly one frame of NFFT samples at a time, with round-robin priority.
- Queues one source tag per granted frame and pops it as the FFT output stream completes each frame, so downstream logic knows which requester produced each output frame.
- Sits between the RX symbol sources and the FFT wrapper input; also snoops the FFT output handshake.

## Interface
Parameters:
- NFFT, 256, samples per frame (power of two)
- CNT_W, 8, log2(NFFT)
- TAG_DEPTH, 4, frame-tag queue depth (power of two)

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset, asynchronous, active-high
- R0_DAT_I  in  32  requester 0 sample, Im[31:16], Re[15:0]
- R0_CYC_I, R0_STB_I, R0_WE_I  in  1 each  requester 0 bus cycle, strobe, write
- R0_ACK_O  out  1  requester 0 acknowledge
- R1_DAT_I, R1_CYC_I, R1_STB_I, R1_WE_I, R1_ACK_O  as above, requester 1
- M_DAT_O  out  32  sample to FFT
- M_CYC_O, M_STB_O, M_WE_O  out  1 each  master signals to FFT
- M_ACK_I  in  1  FFT input acknowledge
- FO_STB_I, FO_ACK_I  in  1 each  FFT output strobe and downstream ack (snooped)
- GNT_O  out  2  one-hot current grant; 00 when idle
- TAG_O  out  1  source of the frame currently leaving the FFT
- TAG_VAL_O  out  1  tag queue not empty
- ERR_O  out  1  sticky: output frame completed with empty tag queue

## Operation
- req_n = Rn_CYC_I & Rn_STB_I & Rn_WE_I.
- Input accept: M_STB_O & M_ACK_I. Output accept: FO_STB_I & FO_ACK_I.
- FSM states: IDLE, BUSY. Owner register `own` holds the granted requester.
- IDLE → BUSY when any req_n is asserted and the tag queue is not full.
  - Owner selection: if only one requests, it wins. If both request, the one that is not `last` wins.
  - On the transition: set `own`, set `last <= own`, push `own` into the tag queue, clear the input counter.
- In BUSY:
  - M_DAT_O, M_STB_O and M_WE_O are driven from the owner. M_CYC_O = 1.
  - Rown_ACK_O = M_ACK_I. The other requester's ACK = 0.
  - Input counter increments on each input accept.
- BUSY → IDLE on the input accept with counter == NFFT-1. The counter wraps to 0.
- A frame is never split:
  - The owner may deassert STB or CYC mid-frame. Grant is held and the counter is frozen until the owner resumes.
  - Requests from the non-owner are ignored until IDLE.
- In IDLE: M_CYC_O, M_STB_O, M_WE_O, both ACKs = 0. M_DAT_O = 0.
- Output counter (CNT_W bits) increments on each output accept. At NFFT-1 it wraps to 0 and pops the tag queue.
- Pop on an empty queue: no state change, ERR_O is set. ERR_O clears only on reset.
- Simultaneous push and pop: occupancy unchanged, head advances, new tag is written.
- Queue full (TAG_DEPTH frames in flight): no new grant. Any ongoing BUSY frame completes normally.

## Timing
- Reset values (asynchronous assert):
  - FSM = IDLE; own = 0; last = 1, so requester 0 wins the first tie.
  - Both counters = 0; queue empty.
  - GNT_O = 00, TAG_O = 0, TAG_VAL_O = 0, ERR_O = 0.
  - All M_* = 0, all ACKs = 0.
- Grant latency: req seen in IDLE at edge t → BUSY and GNT_O valid after edge t. The first sample can be accepted in cycle t+1.
- Datapath mux and ACK routing are combinational: zero added latency, one sample per cycle sustained.
- Inter-frame gap:
  - Last accept at cycle t → IDLE in cycle t+1 → next BUSY in cycle t+2.
  - Exactly one dead cycle between back-to-back frames.
- TAG_O and TAG_VAL_O are registered queue state. The head changes on the cycle after the final output accept.
- Reset mid-frame aborts the grant immediately. No partial-frame recovery is attempted; upstream must restart the frame.

## Structure
- Shared package `fft_sched_pkg`: FSM state encoding (IDLE/BUSY), requester index constants (SRC_PRE = 0, SRC_DATA = 1), default NFFT/CNT_W.
- Sub-module `frame_tag_fifo`: 1-bit-wide, TAG_DEPTH-deep synchronous FIFO with push/pop, full/empty, and async reset.
- All remaining logic (FSM, counters, mux) lives in the top module.

## Test plan
- Single requester: R0 streams 256 samples with M_ACK_I = 1.
  - GNT_O = 01 for exactly 256 accepts, then 00 for 1 cycle.
  - Queue holds 1 tag of value 0.
- Both requesting continuously from reset:
  - Grants alternate R0, R1, R0, R1, each 256 samples, with 1 idle cycle between.
  - Tags pushed in order 0, 1, 0, 1.
- Owner stalls mid-frame: R1 drops STB for 10 cycles at sample 100 while R0 requests.
  - Grant stays 10; counter holds at 100; R0_ACK_O stays 0.
  - The frame completes at 256 samples.
- Queue full: 4 frames granted with no output activity, and R0 requests a fifth.
  - No grant. Then 256 output accepts pop one tag, and the grant follows.
- Output tracking: after frames from R1 then R0, drive 512 output accepts.
  - TAG_O = 1 for the first 256, then 0; TAG_VAL_O falls after the 512th.
  - A further 256 output accepts set ERR_O = 1.
- RST_I pulsed asynchronously at input sample 50.
  - All outputs return to reset values within the same cycle; queue empty.
  - After reset, a fresh R0 frame is granted normally.
